// File: rtl/ball_kinematics_if.sv
// Control and status bundle between one ball_kinematics instance and its neighbours
// (collision logic, key decoder, bitmap drawer).
interface ball_kinematics_if;
   logic               startOfFrame;
   logic               newGame;
   logic               chargeUp;
   logic               chargeDown;
   logic               chargeLeft;
   logic               chargeRight;
   logic               releaseBall;
   logic               collision_with_ball;
   logic signed [10:0] Xspeed_in;
   logic signed [10:0] Yspeed_in;
   logic               collision_with_wall;
   logic        [1:0]  collided_wall;
   logic               pocket_hit;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic signed [10:0] XspeedOUT;
   logic signed [10:0] YspeedOUT;
   logic signed [10:0] shotX;
   logic signed [10:0] shotY;
   logic        [1:0]  state;
   logic               potted;

   modport master (
      output startOfFrame, newGame, chargeUp, chargeDown, chargeLeft, chargeRight,
             releaseBall, collision_with_ball, Xspeed_in, Yspeed_in, collision_with_wall,
             collided_wall, pocket_hit,
      input  topLeftX, topLeftY, XspeedOUT, YspeedOUT, shotX, shotY, state, potted
   );

   modport slave (
      input  startOfFrame, newGame, chargeUp, chargeDown, chargeLeft, chargeRight,
             releaseBall, collision_with_ball, Xspeed_in, Yspeed_in, collision_with_wall,
             collided_wall, pocket_hit,
      output topLeftX, topLeftY, XspeedOUT, YspeedOUT, shotX, shotY, state, potted
   );
endinterface

// File: rtl/ball_kinematics.sv
// Per-ball motion engine: fixed-point integration with friction, cushion damping,
// cue-shot charging and a pocket/respawn life cycle.
module ball_kinematics #(
   parameter int BALL_ID         = 0,
   parameter int INITIAL_X       = 400,
   parameter int INITIAL_Y       = 220,
   parameter int PARK_X          = 600,
   parameter int PARK_Y          = 460,
   parameter int FRAC_BITS       = 6,
   parameter int FRICTION_SHIFT  = 6,
   parameter int WALL_DAMP_SHIFT = 3,
   parameter int MIN_SPEED       = 2,
   parameter int MAX_SHOT        = 512,
   parameter int SPEED_STEP      = 64,
   parameter int RESPAWN_FRAMES  = 60
) (
   input logic               clk,
   input logic               resetN,
   ball_kinematics_if.slave  ball_if
);

   localparam int W = 11 + FRAC_BITS;
   localparam bit IsCue = (BALL_ID == 0);

   localparam logic signed [W-1:0] InitXFx = W'(INITIAL_X << FRAC_BITS);
   localparam logic signed [W-1:0] InitYFx = W'(INITIAL_Y << FRAC_BITS);
   localparam logic signed [W-1:0] ParkXFx = W'(PARK_X << FRAC_BITS);
   localparam logic signed [W-1:0] ParkYFx = W'(PARK_Y << FRAC_BITS);
   localparam logic        [W-1:0] MinThr  = W'(MIN_SPEED << FRAC_BITS);
   localparam logic signed [12:0]  StepW   = 13'(SPEED_STEP);
   localparam logic signed [12:0]  MaxW    = 13'(MAX_SHOT);
   localparam logic        [7:0]   LastCnt = 8'(RESPAWN_FRAMES - 1);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StRolling  = 2'd1,
      StPocketed = 2'd2,
      StRespawn  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic signed [W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [W-1:0]  spd_x_q, spd_x_d, spd_y_q, spd_y_d;
   logic signed [10:0]   shot_x_q, shot_x_d, shot_y_q, shot_y_d;
   logic        [7:0]    cnt_q, cnt_d;
   logic                 potted_q, potted_d;

   // Zeroes the axis once it is slow enough or friction would flip its direction.
   function automatic logic signed [W-1:0] friction(input logic signed [W-1:0] spd);
      logic signed [W-1:0] n;
      logic        [W-1:0] mag;
      logic signed [W-1:0] res;
      n   = spd - (spd >>> FRICTION_SHIFT);
      mag = n[W-1] ? W'(-n) : W'(n);
      res = ((mag <= MinThr) || (n[W-1] != spd[W-1])) ? '0 : n;
      return res;
   endfunction

   function automatic logic signed [W-1:0] rebound(input logic signed [W-1:0] spd);
      logic signed [W-1:0] res;
      res = -(spd - (spd >>> WALL_DAMP_SHIFT));
      return res;
   endfunction

   function automatic logic signed [10:0] charge(input logic signed [10:0] shot,
                                                 input logic inc, input logic dec);
      logic signed [12:0] sum;
      sum = {{2{shot[10]}}, shot};
      if (inc && !dec) sum = sum + StepW;
      else if (dec && !inc) sum = sum - StepW;
      if (sum > MaxW) sum = MaxW;
      else if (sum < -MaxW) sum = -MaxW;
      return sum[10:0];
   endfunction

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= StIdle;
         pos_x_q  <= InitXFx;
         pos_y_q  <= InitYFx;
         spd_x_q  <= '0;
         spd_y_q  <= '0;
         shot_x_q <= '0;
         shot_y_q <= '0;
         cnt_q    <= '0;
         potted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         spd_x_q  <= spd_x_d;
         spd_y_q  <= spd_y_d;
         shot_x_q <= shot_x_d;
         shot_y_q <= shot_y_d;
         cnt_q    <= cnt_d;
         potted_q <= potted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      spd_x_d  = spd_x_q;
      spd_y_d  = spd_y_q;
      shot_x_d = shot_x_q;
      shot_y_d = shot_y_q;
      cnt_d    = cnt_q;
      potted_d = 1'b0;
      if (ball_if.newGame) begin
         state_d  = StIdle;
         pos_x_d  = InitXFx;
         pos_y_d  = InitYFx;
         spd_x_d  = '0;
         spd_y_d  = '0;
         shot_x_d = '0;
         shot_y_d = '0;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            StIdle, StRolling: begin
               if (ball_if.pocket_hit) begin
                  state_d  = StPocketed;
                  pos_x_d  = ParkXFx;
                  pos_y_d  = ParkYFx;
                  spd_x_d  = '0;
                  spd_y_d  = '0;
                  shot_x_d = '0;
                  shot_y_d = '0;
                  potted_d = 1'b1;
               end else begin
                  // Integration always uses the pre-cycle speed.
                  if (state_q == StRolling && ball_if.startOfFrame) begin
                     pos_x_d = pos_x_q + (spd_x_q >>> FRAC_BITS);
                     pos_y_d = pos_y_q + (spd_y_q >>> FRAC_BITS);
                     spd_x_d = friction(spd_x_q);
                     spd_y_d = friction(spd_y_q);
                  end
                  if (ball_if.collision_with_ball) begin
                     spd_x_d = {ball_if.Xspeed_in, {FRAC_BITS{1'b0}}};
                     spd_y_d = {ball_if.Yspeed_in, {FRAC_BITS{1'b0}}};
                     state_d = (ball_if.Xspeed_in != '0 || ball_if.Yspeed_in != '0) ?
                               StRolling : StIdle;
                  end else if (state_q == StRolling) begin
                     if (ball_if.collision_with_wall && ball_if.collided_wall[0] &&
                         spd_x_q != '0) spd_x_d = rebound(spd_x_q);
                     if (ball_if.collision_with_wall && ball_if.collided_wall[1] &&
                         spd_y_q != '0) spd_y_d = rebound(spd_y_q);
                     if (ball_if.startOfFrame && spd_x_d == '0 && spd_y_d == '0)
                        state_d = StIdle;
                  end else if (IsCue) begin
                     if (ball_if.releaseBall) begin
                        spd_x_d  = {shot_x_q, {FRAC_BITS{1'b0}}};
                        spd_y_d  = {shot_y_q, {FRAC_BITS{1'b0}}};
                        shot_x_d = '0;
                        shot_y_d = '0;
                        state_d  = (shot_x_q != '0 || shot_y_q != '0) ? StRolling : StIdle;
                     end else begin
                        shot_x_d = charge(shot_x_q, ball_if.chargeLeft, ball_if.chargeRight);
                        shot_y_d = charge(shot_y_q, ball_if.chargeUp, ball_if.chargeDown);
                     end
                  end
               end
            end
            StPocketed: begin
               if (IsCue) state_d = StRespawn;
            end
            StRespawn: begin
               if (ball_if.startOfFrame) begin
                  if (cnt_q == LastCnt) begin
                     cnt_d   = '0;
                     pos_x_d = InitXFx;
                     pos_y_d = InitYFx;
                     state_d = StIdle;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
         endcase
      end
   end

   assign ball_if.topLeftX  = pos_x_q[W-1:FRAC_BITS];
   assign ball_if.topLeftY  = pos_y_q[W-1:FRAC_BITS];
   assign ball_if.XspeedOUT = spd_x_q[W-1:FRAC_BITS];
   assign ball_if.YspeedOUT = spd_y_q[W-1:FRAC_BITS];
   assign ball_if.shotX     = shot_x_q;
   assign ball_if.shotY     = shot_y_q;
   assign ball_if.state     = state_q;
   assign ball_if.potted    = potted_q;

endmodule

// File: tb/tb_ball_kinematics.sv
// Directed bench: cue ball (ID 0) and an object ball (ID 3) driven side by side.
module tb_ball_kinematics;

   logic clk;
   logic resetN;
   int   total;
   int   bad;

   ball_kinematics_if a_if ();
   ball_kinematics_if b_if ();

   ball_kinematics #(.BALL_ID(0)) u_cue (
      .clk     (clk),
      .resetN  (resetN),
      .ball_if (a_if.slave)
   );

   ball_kinematics #(.BALL_ID(3)) u_obj (
      .clk     (clk),
      .resetN  (resetN),
      .ball_if (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      a_if.startOfFrame = 0; a_if.newGame = 0; a_if.chargeUp = 0; a_if.chargeDown = 0;
      a_if.chargeLeft = 0; a_if.chargeRight = 0; a_if.releaseBall = 0;
      a_if.collision_with_ball = 0; a_if.Xspeed_in = '0; a_if.Yspeed_in = '0;
      a_if.collision_with_wall = 0; a_if.collided_wall = '0; a_if.pocket_hit = 0;
      b_if.startOfFrame = 0; b_if.newGame = 0; b_if.chargeUp = 0; b_if.chargeDown = 0;
      b_if.chargeLeft = 0; b_if.chargeRight = 0; b_if.releaseBall = 0;
      b_if.collision_with_ball = 0; b_if.Xspeed_in = '0; b_if.Yspeed_in = '0;
      b_if.collision_with_wall = 0; b_if.collided_wall = '0; b_if.pocket_hit = 0;
   endtask

   task automatic a_sof();
      a_if.startOfFrame = 1; tick(); a_if.startOfFrame = 0;
   endtask

   task automatic a_ball(input logic signed [10:0] xs, input logic signed [10:0] ys);
      a_if.collision_with_ball = 1; a_if.Xspeed_in = xs; a_if.Yspeed_in = ys;
      tick();
      a_if.collision_with_ball = 0; a_if.Xspeed_in = '0; a_if.Yspeed_in = '0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      resetN = 1'b0;
      clear_inputs();
      tick();
      chk("rst_x", a_if.topLeftX, 400);
      chk("rst_y", a_if.topLeftY, 220);
      chk("rst_vx", a_if.XspeedOUT, 0);
      chk("rst_vy", a_if.YspeedOUT, 0);
      chk("rst_state", a_if.state, 0);
      chk("rst_potted", a_if.potted, 0);
      resetN = 1'b1;
      tick();

      // Two charge pulses and release
      a_if.chargeLeft = 1; tick(); a_if.chargeLeft = 0;
      a_if.chargeLeft = 1; tick(); a_if.chargeLeft = 0;
      chk("shot_x_128", a_if.shotX, 128);
      a_if.releaseBall = 1; tick(); a_if.releaseBall = 0;
      chk("rel_vx", a_if.XspeedOUT, 128);
      chk("rel_state", a_if.state, 1);
      chk("rel_shot_clr", a_if.shotX, 0);
      a_sof();
      chk("frame1_x", a_if.topLeftX, 402);
      chk("frame1_vx", a_if.XspeedOUT, 126);

      // Cushion rebound at speed 128, then a flagged axis already at zero
      a_ball(128, 0);
      chk("ball128_vx", a_if.XspeedOUT, 128);
      a_if.collision_with_wall = 1; a_if.collided_wall = 2'b01; tick();
      a_if.collision_with_wall = 0; a_if.collided_wall = 2'b00;
      chk("wall_vx", a_if.XspeedOUT, -112);
      chk("wall_vy", a_if.YspeedOUT, 0);
      a_if.collision_with_wall = 1; a_if.collided_wall = 2'b10; tick();
      a_if.collision_with_wall = 0; a_if.collided_wall = 2'b00;
      chk("wall0_vx", a_if.XspeedOUT, -112);
      chk("wall0_vy", a_if.YspeedOUT, 0);

      // Slow ball stops on the next frame
      a_ball(2, 0);
      chk("slow_state", a_if.state, 1);
      a_sof();
      chk("stop_vx", a_if.XspeedOUT, 0);
      chk("stop_state", a_if.state, 0);
      chk("stop_x", a_if.topLeftX, 402);

      // Negative and positive friction with floor rounding
      a_ball(-100, 50);
      a_sof();
      chk("neg_x", a_if.topLeftX, 400);
      chk("neg_y", a_if.topLeftY, 220);
      chk("neg_vx", a_if.XspeedOUT, -99);
      chk("pos_vy", a_if.YspeedOUT, 49);
      a_ball(0, 0);
      chk("zero_ball_state", a_if.state, 0);

      // Charge saturation
      for (int i = 0; i < 10; i++) begin
         a_if.chargeUp = 1; tick(); a_if.chargeUp = 0;
         chk($sformatf("sat_y%0d", i), a_if.shotY, (i < 7) ? 64 * (i + 1) : 512);
      end
      a_if.chargeDown = 1; tick(); a_if.chargeDown = 0;
      chk("down_y", a_if.shotY, 448);
      a_if.chargeLeft = 1; a_if.chargeRight = 1; tick();
      a_if.chargeLeft = 0; a_if.chargeRight = 0;
      chk("oppose_x", a_if.shotX, 0);
      a_if.chargeRight = 1; tick(); a_if.chargeRight = 0;
      chk("right_x", a_if.shotX, -64);
      a_if.releaseBall = 1; tick(); a_if.releaseBall = 0;
      chk("rel2_vx", a_if.XspeedOUT, -64);
      chk("rel2_vy", a_if.YspeedOUT, 448);
      chk("rel2_shot_y", a_if.shotY, 0);

      // Cue ball pocket and respawn
      a_if.pocket_hit = 1; tick(); a_if.pocket_hit = 0;
      chk("pot_pulse", a_if.potted, 1);
      chk("pot_state", a_if.state, 2);
      chk("pot_x", a_if.topLeftX, 600);
      chk("pot_y", a_if.topLeftY, 460);
      chk("pot_vy", a_if.YspeedOUT, 0);
      tick();
      chk("pot_pulse_end", a_if.potted, 0);
      chk("respawn_state", a_if.state, 3);
      a_if.chargeUp = 1; tick(); a_if.chargeUp = 0;
      chk("respawn_no_charge", a_if.shotY, 0);
      for (int i = 0; i < 59; i++) a_sof();
      chk("respawn59_state", a_if.state, 3);
      chk("respawn59_x", a_if.topLeftX, 600);
      a_sof();
      chk("respawn60_state", a_if.state, 0);
      chk("respawn60_x", a_if.topLeftX, 400);
      chk("respawn60_y", a_if.topLeftY, 220);

      // Object ball stays pocketed until newGame
      b_if.pocket_hit = 1; tick(); b_if.pocket_hit = 0;
      chk("obj_potted", b_if.potted, 1);
      chk("obj_x", b_if.topLeftX, 600);
      b_if.startOfFrame = 1;
      for (int i = 0; i < 70; i++) tick();
      b_if.startOfFrame = 0;
      chk("obj_hold_state", b_if.state, 2);
      chk("obj_potted_end", b_if.potted, 0);
      b_if.chargeLeft = 1; tick(); b_if.chargeLeft = 0;
      chk("obj_no_charge", b_if.shotX, 0);
      b_if.newGame = 1; tick(); b_if.newGame = 0;
      chk("obj_ng_state", b_if.state, 0);
      chk("obj_ng_x", b_if.topLeftX, 400);
      chk("obj_ng_y", b_if.topLeftY, 220);

      // Asynchronous reset mid-roll
      a_if.chargeLeft = 1; tick(); a_if.chargeLeft = 0;
      a_if.releaseBall = 1; tick(); a_if.releaseBall = 0;
      a_sof();
      chk("roll_x", a_if.topLeftX, 401);
      #2 resetN = 1'b0;
      #1;
      chk("arst_state", a_if.state, 0);
      chk("arst_x", a_if.topLeftX, 400);
      chk("arst_vx", a_if.XspeedOUT, 0);
      resetN = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ball_kinematics.md
# ball_kinematics

Parametrised per-ball motion engine for the billiard table. It is the successor to the single-ball move/collision block. It adds:
- a four-state life-cycle FSM (idle, rolling, pocketed, respawn);
- configurable fixed-point resolution, friction and wall damping;
- saturating cue-shot charging;
- pocket parking with timed cue-ball respawn.

One instance sits per ball, between the collision/speed-exchange logic and the ball bitmap drawers.

## Interface
- BALL_ID, 0: 0 = cue ball; only ID 0 charges shots and respawns.
- INITIAL_X / INITIAL_Y, 400 / 220: start and respawn top-left, pixels.
- PARK_X / PARK_Y, 600 / 460: off-table top-left used while pocketed.
- FRAC_BITS, 6: fractional bits of position and speed registers.
- FRICTION_SHIFT, 6: per-frame decay is spd >>> FRICTION_SHIFT.
- WALL_DAMP_SHIFT, 3: rebound loss is spd >>> WALL_DAMP_SHIFT.
- MIN_SPEED, 2: stop threshold, integer speed units.
- MAX_SHOT, 512: shot magnitude limit, must be ≤ 1023.
- SPEED_STEP, 64: shot increment per charge pulse.
- RESPAWN_FRAMES, 60: frames spent in RESPAWN.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- newGame  in  1  sync pulse: back to INITIAL, IDLE, all zero
- chargeUp / chargeDown / chargeLeft / chargeRight  in  1 each  one-cycle key pulses
- releaseBall  in  1  fire the charged shot
- collision_with_ball  in  1  load Xspeed_in/Yspeed_in
- Xspeed_in / Yspeed_in  in  11 signed  post-impact speed, integer units
- collision_with_wall  in  1  cushion hit
- collided_wall  in  2  bit1 = horizontal cushion (reflect Y), bit0 = vertical cushion (reflect X)
- pocket_hit  in  1  ball overlaps a hole
- topLeftX / topLeftY  out  11 signed  pixel position
- XspeedOUT / YspeedOUT  out  11 signed  integer speed (1/2^FRAC_BITS px per frame)
- shotX / shotY  out  11 signed  current charge, for the aim indicator
- state  out  2  0 IDLE, 1 ROLLING, 2 POCKETED, 3 RESPAWN
- potted  out  1  one-cycle pulse on entry to POCKETED

## Operation

**Registers**
- posX_fx/posY_fx: signed (11+FRAC_BITS), units 1/2^FRAC_BITS pixel.
- spdX_fx/spdY_fx: signed (11+FRAC_BITS).
- shotX/shotY: signed 11.
- FSM state; 8-bit frame counter.

**Derived values**
- Integer speed spd = spd_fx >>> FRAC_BITS (arithmetic shift, floor).
- topLeft = pos_fx >>> FRAC_BITS.

**Frame update**, on startOfFrame in ROLLING, per axis:
- pos_fx += spd.
- Let n = spd_fx − (spd_fx >>> FRICTION_SHIFT).
- If |n| ≤ MIN_SPEED<<FRAC_BITS, or sign(n) ≠ sign(spd_fx), the axis is zeroed; otherwise spd_fx = n.
- When both axes are zero after the update, go to IDLE.

**Charge** (BALL_ID 0, IDLE only), each pulse:
- chargeLeft: shotX += STEP.
- chargeRight: shotX −= STEP.
- chargeUp: shotY += STEP.
- chargeDown: shotY −= STEP.
- Results saturate at ±MAX_SHOT.
- Opposing pulses in the same cycle leave the value unchanged.

**Release** (BALL_ID 0, IDLE):
- spd_fx = shot << FRAC_BITS; shot cleared.
- Go to ROLLING if either shot component was nonzero; otherwise stay in IDLE.

**Ball collision** (IDLE or ROLLING):
- spd_fx = speed_in << FRAC_BITS.
- Go to ROLLING if nonzero; otherwise go to IDLE.

**Wall collision** (ROLLING), per flagged axis with spd_fx ≠ 0:
- spd_fx = −(spd_fx − (spd_fx >>> WALL_DAMP_SHIFT)).
- An axis with zero speed is unchanged.

**pocket_hit** (IDLE or ROLLING):
- Speeds and shot cleared; position set to PARK; state POCKETED; potted pulses.
- BALL_ID 0 goes straight on to RESPAWN on the next cycle.
- BALL_ID ≠ 0 stays in POCKETED until newGame or reset.

**RESPAWN**:
- Position held at PARK.
- Frame counter counts startOfFrame pulses.
- At RESPAWN_FRAMES: position = INITIAL, counter cleared, state IDLE.

**Ignored inputs**
- POCKETED and RESPAWN ignore collisions, charge and release.
- Charge and release are ignored outside IDLE and for BALL_ID ≠ 0.

**Same-cycle priority:** newGame > pocket_hit > collision_with_ball > collision_with_wall > releaseBall > charge > frame update.
- A lower-priority speed write to the same axis is dropped.
- Frame position integration still uses the pre-cycle speed when a collision coincides.

## Timing
- Reset values:
  - topLeft = (INITIAL_X, INITIAL_Y);
  - all speeds and shots 0;
  - state IDLE; potted 0; counter 0.
- All state updates on the posedge of clk. Outputs derive only from registers; there is no combinational path from input to output.
- Speed and state effects of any event are visible 1 cycle after it.
- Position changes only in the cycle after a startOfFrame, or on a pocket/respawn/newGame event.
- resetN asserted mid-roll or mid-respawn aborts immediately to reset values.

## Test plan
- Reset → topLeft (400,220), XspeedOUT/YspeedOUT 0, state 0, potted 0.
- 2×chargeLeft, releaseBall → next cycle XspeedOUT 128, state 1. First startOfFrame → topLeftX 402, XspeedOUT 126.
- 10×chargeUp → shotY 64,128…512, then held at 512. 1×chargeDown → 448.
- Rolling with XspeedOUT 128, collision_with_wall with collided_wall=01 → XspeedOUT −112, YspeedOUT unchanged. Same with speed 0 → no change.
- collision_with_ball with Xspeed_in 2, Yspeed_in 0 → state 1. Next startOfFrame → speeds 0, state 0.
- pocket_hit: potted high exactly 1 cycle; topLeft (600,460).
  - BALL_ID 0: state 3, then (400,220) and state 0 after 60 frames.
  - BALL_ID 3: state 2 indefinitely; newGame → (400,220), state 0.
